// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder over a word RAM with wait states and fault flagging
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_type,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_type, r_uns, r_err;
  logic [1:0] r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [31:0] r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0] w_lane;
  logic w_access, w_err, w_we;
  logic [3:0] w_mask;
  logic [31:0] w_wd, w_word, w_ld;
  logic [15:0] w_half;
  logic [7:0] w_byte;
  assign w_idx = r_addr[ADDR_WIDTH+1:2];
  assign w_lane = r_addr[1:0];
  assign w_access = r_state == WAIT && r_cnt == 4'd0;
  assign w_err = r_size == 2'b11 || (r_size == 2'b01 && r_addr[0]) ||
                 (r_size == 2'b10 && w_lane != 2'b00) || r_addr[31:ADDR_WIDTH+2] != '0;
  assign w_we = w_access && r_type && !w_err;
  assign w_word = r_mem[w_idx];
  assign w_byte = 8'(w_word >> {w_lane, 3'b000});
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
  assign w_ld = r_size == 2'b00 ? {{24{w_byte[7] & ~r_uns}}, w_byte} :
                r_size == 2'b01 ? {{16{w_half[15] & ~r_uns}}, w_half} : w_word;
  assign w_mask = r_size == 2'b00 ? 4'b0001 << w_lane :
                  r_size == 2'b01 ? (w_lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wd = r_size == 2'b00 ? {4{r_wdata[7:0]}} :
                r_size == 2'b01 ? {2{r_wdata[15:0]}} : r_wdata;
  assign resp_rdata = r_rdata;
  assign resp_err = r_err;
  always_comb begin
    w_next = r_state;
    req_ready = r_state == IDLE;
    resp_valid = r_state == RESP;
    if (r_state == IDLE && req_valid) w_next = WAIT;
    else if (w_access) w_next = RESP;
    else if (r_state == RESP && resp_ready) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_type <= 1'b0;
      r_size <= '0;
      r_uns <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_cnt <= 4'(WAIT_CYCLES);
        r_type <= req_type;
        r_size <= req_size;
        r_uns <= req_unsigned;
        r_addr <= req_addr;
        r_wdata <= req_wdata;
      end else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_access) begin
        r_rdata <= (w_err || r_type) ? 32'd0 : w_ld;
        r_err <= w_err;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (w_we && w_mask[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against a byte-array model
module tb_dmem_responder;
  localparam int AW = 10;
  localparam int WC = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_type = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic resp_valid, resp_ready = 1'b1, resp_err;
  logic [31:0] resp_rdata;
  int total = 0, passed = 0, fails = 0;
  bit [7:0] mb [64];
  logic [31:0] rd, held, pre20;
  logic er;
  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic int nbytes(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic m_err(input logic [1:0] s, input logic [31:0] a);
    return s == 2'd3 || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0) || (a >> (AW + 2)) != 0;
  endfunction
  function automatic logic [31:0] m_load(input logic [1:0] s, input logic u, input logic [31:0] a);
    int n = nbytes(s);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v |= 32'(mb[int'(a % 64) + i]) << (8 * i);
    if (!u && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction
  task automatic m_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < nbytes(s); i++) mb[int'(a % 64) + i] = 8'(wd >> (8 * i));
  endtask
  task automatic do_req(input logic t, input logic [1:0] s, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] o_rd, output logic o_er);
    logic e_er;
    logic [31:0] e_rd;
    int lat = 0;
    e_er = m_err(s, a);
    e_rd = (e_er || t) ? 32'd0 : m_load(s, u, a);
    @(negedge clk);
    req_valid = 1'b1; req_type = t; req_size = s; req_unsigned = u; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_type = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    chk("ready_low_after_accept", 32'(req_ready), 32'd0);
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, WC + 1);
    o_rd = resp_rdata;
    o_er = resp_err;
    chk("rdata", o_rd, e_rd);
    chk("err", 32'(o_er), 32'(e_er));
    if (!e_er && t) m_store(s, a, wd);
    if (resp_ready) begin
      @(posedge clk); #1;
      chk("resp_valid_drop", 32'(resp_valid), 32'd0);
      chk("ready_back", 32'(req_ready), 32'd1);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, rd, er);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    chk("word_load_10", rd, 32'hDEADBEEF);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h12345680, rd, er);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er);
    chk("byte_signed_13", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er);
    chk("byte_unsigned_13", rd, 32'h00000080);
    do_req(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, rd, er);
    chk("word_after_byte", rd, 32'h80ADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, pre20, er);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD1234, rd, er);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, rd, er);
    chk("half_signed_22", rd, 32'h00001234);
    do_req(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, rd, er);
    chk("half_mis_err", 32'(er), 32'd1);
    chk("half_mis_rdata", rd, 32'd0);
    do_req(1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFFFFFF, rd, er);
    chk("word_mis_err", 32'(er), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
    chk("word_20_unchanged", rd, {16'h1234, pre20[15:0]});
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, rd, er);
    chk("range_err", 32'(er), 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd, er);
    chk("size11_err", 32'(er), 32'd1);
    resp_ready = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, held, er);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_type = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'h0;
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, held);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_valid", 32'(resp_valid), 32'd0);
    chk("hold_release_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    chk("held_store_ignored", rd, 32'h80ADBEEF);
    @(negedge clk);
    req_valid = 1'b1; req_type = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    chk("abort_err", 32'(resp_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er);
    chk("abort_store_dropped", rd, m_load(2'd2, 1'b0, 32'h30));
    for (int k = 0; k < 80; k++) begin
      int r = $urandom_range(0, 9);
      logic [31:0] a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a |= 32'd1 << $urandom_range(AW + 2, 31);
      do_req(1'($urandom), r < 3 ? 2'd0 : r < 6 ? 2'd1 : r < 9 ? 2'd2 : 2'd3,
             1'($urandom), a, $urandom, rd, er);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
